// File: rtl/operand_loader.sv
// Purpose : packs A then B from a shared operand bus into one registered a/b pair for the CLA adder.
// Latency : a/b/op_valid are visible in the cycle after the edge that samples the B beat.
// Backpres: none; every valid beat is accepted, so a continuous stream gives one pair per two cycles.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   ab_in, ab_valid  - shared operand bus (A beat, then B beat) and its valid
//   flush            - drop a half-loaded pair and any beat arriving in the same cycle
//   a, b             - registered operand pair; both change together on the B-beat edge
//   op_valid         - one-cycle pulse marking a newly visible a/b pair
//   phase            - 0 while waiting for A, 1 while waiting for B
//   pair_count       - completed pairs, wrapping modulo 2^CNT_W
module operand_loader #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ab_in,
    input  logic             ab_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             op_valid,
    output logic             phase,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic {
        S_WAIT_A = 1'b0,
        S_WAIT_B = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] a_stage_q,    a_stage_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             op_valid_q,   op_valid_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    always_comb begin
        state_d      = state_q;
        a_stage_d    = a_stage_q;
        a_d          = a_q;
        b_d          = b_q;
        op_valid_d   = 1'b0;
        pair_count_d = pair_count_q;

        if (flush) begin
            // Flush overrides any beat in the same cycle; the visible pair is left untouched.
            state_d = S_WAIT_A;
        end else if (ab_valid) begin
            unique case (state_q)
                S_WAIT_A: begin
                    a_stage_d = ab_in;
                    state_d   = S_WAIT_B;
                end
                S_WAIT_B: begin
                    // a and b move together so the adder never sees a mixed old/new pair.
                    a_d          = a_stage_q;
                    b_d          = ab_in;
                    op_valid_d   = 1'b1;
                    pair_count_d = pair_count_q + 1'b1;
                    state_d      = S_WAIT_A;
                end
                default: state_d = S_WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_A;
            a_stage_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_valid_q   <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_stage_q    <= a_stage_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_valid_q   <= op_valid_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign op_valid   = op_valid_q;
    assign phase      = (state_q == S_WAIT_B);
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int WIDTH = 7;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] ab_in;
    logic             ab_valid;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_valid;
    logic             phase;
    logic [CNT_W-1:0] pair_count;

    operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ab_in      (ab_in),
        .ab_valid   (ab_valid),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .op_valid   (op_valid),
        .phase      (phase),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [CNT_W-1:0] cnt;
    } pair_t;

    // Reference model: beats waiting to be paired, the last visible pair and a plain integer count.
    pair_t            exp_q[$];
    logic [WIDTH-1:0] pend[$];
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    int               m_cnt;
    logic             m_ov;

    int checks;
    int errors;
    bit mon_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check the registered outputs.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic fl, input logic r);
        pair_t p;
        ab_valid = v;
        ab_in    = d;
        flush    = fl;
        rst      = r;
        @(posedge clk);
        m_ov = 1'b0;
        if (r) begin
            pend.delete();
            m_a   = '0;
            m_b   = '0;
            m_cnt = 0;
        end else if (fl) begin
            pend.delete();
        end else if (v) begin
            if (pend.size() == 0) begin
                pend.push_back(d);
            end else begin
                m_a   = pend.pop_front();
                m_b   = d;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_ov  = 1'b1;
                p.pa  = m_a;
                p.pb  = m_b;
                p.cnt = m_cnt[CNT_W-1:0];
                exp_q.push_back(p);
            end
        end
        #1;
        chk("phase", 32'(phase), 32'(pend.size()));
        chk("a", 32'(a), 32'(m_a));
        chk("b", 32'(b), 32'(m_b));
        chk("op_valid", 32'(op_valid), 32'(m_ov));
        chk("pair_count", 32'(pair_count), 32'(m_cnt));
    endtask

    initial begin
        logic [7:0] sum;
        checks   = 0;
        errors   = 0;
        mon_on   = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_cnt    = 0;
        m_ov     = 1'b0;
        rst      = 1'b1;
        ab_valid = 1'b0;
        ab_in    = '0;
        flush    = 1'b0;

        // Scoreboard monitor: every op_valid pulse must match the oldest expected pair.
        fork
            forever begin
                @(negedge clk);
                if (mon_on && op_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: op_valid with a=0x%0h b=0x%0h, no pair expected", a, b);
                    end else begin
                        pair_t e;
                        e = exp_q.pop_front();
                        chk("sb_a", 32'(a), 32'(e.pa));
                        chk("sb_b", 32'(b), 32'(e.pb));
                        chk("sb_count", 32'(pair_count), 32'(e.cnt));
                    end
                end
            end
        join_none

        // Reset held two cycles while the bus carries junk.
        step(1'b1, 7'h55, 1'b0, 1'b1);
        step(1'b1, 7'h55, 1'b0, 1'b1);
        mon_on = 1'b1;
        step(1'b0, 7'h00, 1'b0, 1'b0);

        // Basic pair, then a hold cycle.
        step(1'b1, 7'h12, 1'b0, 1'b0);
        step(1'b1, 7'h34, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);

        // Gapped beats: phase stays 1 and the old pair stays visible until B.
        step(1'b1, 7'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 7'(i), 1'b0, 1'b0);
        step(1'b1, 7'h01, 1'b0, 1'b0);
        sum = {1'b0, a} + {1'b0, b};
        chk("adder_sum", 32'(sum), 32'h80);

        // Flush drops the staged A and the B beat presented with it.
        step(1'b1, 7'h0A, 1'b0, 1'b0);
        step(1'b1, 7'h0B, 1'b1, 1'b0);
        step(1'b1, 7'h03, 1'b0, 1'b0);
        step(1'b1, 7'h04, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);

        // 16 back-to-back pairs: wraps the counter.
        for (int i = 0; i < 32; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);

        // Random mix of beats, idles, flushes and occasional resets.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 59) == 0);
        end
        step(1'b0, 7'h00, 1'b0, 1'b0);

        // Reset mid-pair drops the staged A; the next single beat only advances phase.
        step(1'b1, 7'h22, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b1);
        step(1'b1, 7'h33, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
